// File: rtl/int_bus_arbiter.sv
// rtl/int_bus_arbiter.sv - internal-bus arbiter with hold limit and gap cycle; INT_BUS_ARB_RR_EN selects round-robin
`ifndef MUX_INT_BUS_SEL_WIDTH
`define MUX_INT_BUS_SEL_WIDTH 7
`endif

module int_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [`MUX_INT_BUS_SEL_WIDTH-1:0] req,
    input  logic                              alu_req,
    output logic [`MUX_INT_BUS_SEL_WIDTH-1:0] data_select,
    output logic [`MUX_INT_BUS_SEL_WIDTH-1:0] gnt_pulse,
    output logic                              busy
);

    localparam int          NSRC     = `MUX_INT_BUS_SEL_WIDTH;
    localparam logic [3:0]  HOLD_LIM = 4'(MAX_HOLD);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [NSRC-1:0] r_sel;
    logic [NSRC-1:0] w_sel_nxt;
    logic [NSRC-1:0] r_pulse;
    logic [NSRC-1:0] w_pulse_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;
    logic [NSRC-1:0] w_win_onehot;
    logic            w_win_valid;
    logic            w_req_held;

`ifdef INT_BUS_ARB_RR_EN
    logic [2:0]      r_last;
    logic [2:0]      w_last_nxt;
    logic [2:0]      w_win_idx;
    logic [3:0]      w_idx;

    // Round-robin pick: scan from the source after the last winner, wrapping 6 -> 0
    always_comb begin
        w_win_onehot = '0;
        w_win_valid  = 1'b0;
        w_win_idx    = 3'd0;
        w_idx        = 4'd0;
        for (int k = 1; k <= NSRC; k++) begin
            w_idx = 4'(r_last) + 4'(k);
            if (w_idx >= 4'(NSRC)) begin
                w_idx = w_idx - 4'(NSRC);
            end
            if (!w_win_valid && req[w_idx[2:0]]) begin
                w_win_valid               = 1'b1;
                w_win_idx                 = w_idx[2:0];
                w_win_onehot[w_idx[2:0]]  = 1'b1;
            end
        end
    end
`else
    // Fixed-priority pick: lowest set request index wins
    always_comb begin
        w_win_onehot = '0;
        w_win_valid  = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            if (!w_win_valid && req[k]) begin
                w_win_valid     = 1'b1;
                w_win_onehot[k] = 1'b1;
            end
        end
    end
`endif

    assign w_req_held = |(req & r_sel);

    // Next-state and next-output decode; only the granted request bit matters outside IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_pulse_nxt = '0;
        w_cnt_nxt   = r_cnt;
`ifdef INT_BUS_ARB_RR_EN
        w_last_nxt  = r_last;
`endif
        case (r_state)
            S_IDLE: begin
                w_sel_nxt = '0;
                w_cnt_nxt = 4'd0;
                if (!alu_req && w_win_valid) begin
                    w_state_nxt = S_GRANT;
                    w_sel_nxt   = w_win_onehot;
                    w_pulse_nxt = w_win_onehot;
                    w_cnt_nxt   = 4'd1;
`ifdef INT_BUS_ARB_RR_EN
                    w_last_nxt  = w_win_idx;
`endif
                end
            end
            S_GRANT: begin
                if (w_req_held && (r_cnt < HOLD_LIM)) begin
                    w_cnt_nxt = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
                end else begin
                    w_state_nxt = S_GAP;
                    w_sel_nxt   = '0;
                    w_cnt_nxt   = 4'd0;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = '0;
                w_cnt_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = '0;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State and registered outputs; reset drops the grant immediately with no gap cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_pulse <= '0;
            r_cnt   <= 4'd0;
`ifdef INT_BUS_ARB_RR_EN
            r_last  <= 3'd6;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_pulse <= w_pulse_nxt;
            r_cnt   <= w_cnt_nxt;
`ifdef INT_BUS_ARB_RR_EN
            r_last  <= w_last_nxt;
`endif
        end
    end

    assign data_select = r_sel;
    assign gnt_pulse   = r_pulse;
    assign busy        = |r_sel;

endmodule
